// File: rtl/rcpu_pkg.sv
// Shared definitions for the rcpu memory arbiter: word width,
// access owner tags and arbiter state encoding.
package rcpu_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CPU  = 2'd1,
        OWNER_DMA  = 2'd2
    } owner_t;

    typedef enum logic {
        IDLE     = 1'b0,
        DMA_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rcpu_mem_arbiter_if.sv
// Bundle of CPU, DMA and RAM-side signals around the memory arbiter.
// The arbiter takes the slave view; requesters and RAM take the master view.
interface rcpu_mem_arbiter_if;
    import rcpu_pkg::*;

    logic              c_req;
    logic              c_we;
    logic [WORD_W-1:0] c_addr;
    logic [WORD_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [WORD_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic [WORD_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic              d_lock;
    logic              d_gnt;
    logic              d_rvalid;
    logic [WORD_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_lock,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata, d_lock,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/rcpu_mem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-port synchronous RAM,
// with DMA starvation promotion and a bounded DMA bus lock.
module rcpu_mem_arbiter
    import rcpu_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int LOCK_MAX = 16
) (
    input  logic                clk,
    input  logic                reset,
    rcpu_mem_arbiter_if.slave   bus
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);

    arb_state_t    state;
    arb_state_t    state_n;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_n;
    logic [LW-1:0] lock_cnt;
    logic [LW-1:0] lock_n;
    logic          cpu_prio;
    logic          prio_n;
    owner_t        pend;
    owner_t        pend_n;
    owner_t        win;
    logic          c_win;
    logic          d_win;
    logic          win_we;

    // cpu_prio is a one-cycle token handed to the CPU after a lock timeout
    always_comb begin
        win = OWNER_NONE;
        priority case (1'b1)
            state == DMA_LOCK && bus.d_req:          win = OWNER_DMA;
            cpu_prio && bus.c_req:                   win = OWNER_CPU;
            wait_cnt == WW'(MAX_WAIT) && bus.d_req:  win = OWNER_DMA;
            bus.c_req:                               win = OWNER_CPU;
            bus.d_req:                               win = OWNER_DMA;
            default:                                 win = OWNER_NONE;
        endcase
        if (reset) begin
            win = OWNER_NONE;
        end
    end

    assign c_win  = (win == OWNER_CPU);
    assign d_win  = (win == OWNER_DMA);
    assign win_we = c_win ? bus.c_we : (d_win ? bus.d_we : 1'b0);

    always_comb begin
        state_n = state;
        lock_n  = lock_cnt;
        prio_n  = 1'b0;
        wait_n  = wait_cnt;
        pend_n  = OWNER_NONE;

        if (!bus.d_req || d_win) begin
            wait_n = '0;
        end else if (wait_cnt != WW'(MAX_WAIT)) begin
            wait_n = wait_cnt + WW'(1);
        end

        if (win != OWNER_NONE && !win_we) begin
            pend_n = win;
        end

        unique case (state)
            IDLE: begin
                if (d_win && bus.d_lock) begin
                    if (LOCK_MAX <= 1) begin
                        prio_n = 1'b1;
                    end else begin
                        state_n = DMA_LOCK;
                        lock_n  = LW'(1);
                    end
                end
            end
            DMA_LOCK: begin
                if (!bus.d_req || (d_win && !bus.d_lock)) begin
                    state_n = IDLE;
                    lock_n  = '0;
                end else if (d_win && lock_cnt == LW'(LOCK_MAX - 1)) begin
                    state_n = IDLE;
                    lock_n  = '0;
                    prio_n  = 1'b1;
                end else if (d_win) begin
                    lock_n = lock_cnt + LW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                lock_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            lock_cnt <= '0;
            cpu_prio <= 1'b0;
            pend     <= OWNER_NONE;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
            lock_cnt <= lock_n;
            cpu_prio <= prio_n;
            pend     <= pend_n;
        end
    end

    assign bus.c_gnt     = c_win;
    assign bus.d_gnt     = d_win;
    assign bus.mem_en    = c_win | d_win;
    assign bus.mem_we    = win_we;
    assign bus.mem_addr  = c_win ? bus.c_addr
                         : (d_win ? bus.d_addr : '0);
    assign bus.mem_wdata = c_win ? bus.c_wdata
                         : (d_win ? bus.d_wdata : '0);

    // pend may still hold a tag during the first reset cycle
    assign bus.c_rvalid = !reset && pend == OWNER_CPU;
    assign bus.d_rvalid = !reset && pend == OWNER_DMA;
    assign bus.c_rdata  = bus.c_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_rcpu_mem_arbiter.sv
// Directed-vector bench for rcpu_mem_arbiter with a small RAM model.
module tb_rcpu_mem_arbiter;
    import rcpu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [15:0] ram [0:255];

    rcpu_mem_arbiter_if bus ();

    rcpu_mem_arbiter #(.MAX_WAIT(4), .LOCK_MAX(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we)
            ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        if (bus.mem_en && !bus.mem_we)
            bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.d_lock = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'(i);
        ram[8'h05] = 16'h5A5A;
        ram[8'h02] = 16'h2222;
        ram[8'h10] = 16'hBEEF;
        bus.mem_rdata = '0;
        idle_all();

        // reset with a CPU read pending on the inputs
        tick();
        bus.c_req = 1; bus.c_addr = 16'h0005;
        #3;
        chk("rst_c_gnt", bus.c_gnt, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_c_rvalid", bus.c_rvalid, 0);
        chk("rst_state", dut.state, IDLE);
        chk("rst_wait", dut.wait_cnt, 0);
        tick();
        reset = 0;
        #3;
        chk("rel_c_gnt", bus.c_gnt, 1);
        chk("rel_c_rvalid", bus.c_rvalid, 0);
        tick();
        idle_all();
        #3;
        chk("rel_rv", bus.c_rvalid, 1);
        chk("rel_rdata", bus.c_rdata, 16'h5A5A);

        // contention and promotion: c c c c d c
        tick();
        bus.c_req = 1; bus.c_addr = 16'h0001;
        bus.d_req = 1; bus.d_addr = 16'h0002;
        for (int k = 0; k < 6; k++) begin
            #3;
            chk($sformatf("prom_c%0d", k), bus.c_gnt, (k == 4) ? 0 : 1);
            chk($sformatf("prom_d%0d", k), bus.d_gnt, (k == 4) ? 1 : 0);
            if (k == 1) chk("prom_c_rv1", bus.c_rvalid, 1);
            if (k == 5) begin
                chk("prom_d_rv5", bus.d_rvalid, 1);
                chk("prom_d_rd5", bus.d_rdata, 16'h2222);
                chk("prom_c_rv5", bus.c_rvalid, 0);
            end
            tick();
        end
        idle_all();

        // DMA read
        tick();
        bus.d_req = 1; bus.d_addr = 16'h0010;
        #3;
        chk("dr_gnt", bus.d_gnt, 1);
        chk("dr_addr", bus.mem_addr, 16'h0010);
        tick();
        bus.d_req = 0;
        #3;
        chk("dr_rv", bus.d_rvalid, 1);
        chk("dr_rdata", bus.d_rdata, 16'hBEEF);
        chk("dr_c_rv", bus.c_rvalid, 0);
        chk("dr_c_rdata", bus.c_rdata, 0);
        tick();
        #3;
        chk("dr_pulse", bus.d_rvalid, 0);

        // CPU write
        tick();
        bus.c_req = 1; bus.c_we = 1;
        bus.c_addr = 16'h0042; bus.c_wdata = 16'h1234;
        #3;
        chk("cw_gnt", bus.c_gnt, 1);
        chk("cw_en", bus.mem_en, 1);
        chk("cw_we", bus.mem_we, 1);
        chk("cw_addr", bus.mem_addr, 16'h0042);
        chk("cw_wdata", bus.mem_wdata, 16'h1234);
        tick();
        idle_all();
        #3;
        chk("cw_norv", bus.c_rvalid, 0);

        // lock timeout: 4 CPU, 16 DMA, then CPU
        tick();
        bus.c_req = 1; bus.c_addr = 16'h0003;
        bus.d_req = 1; bus.d_we = 1; bus.d_lock = 1;
        bus.d_addr = 16'h0080; bus.d_wdata = 16'hAAAA;
        for (int k = 0; k < 21; k++) begin
            #3;
            chk($sformatf("lk_c%0d", k), bus.c_gnt,
                (k < 4 || k == 20) ? 1 : 0);
            chk($sformatf("lk_d%0d", k), bus.d_gnt,
                (k >= 4 && k < 20) ? 1 : 0);
            if (k == 5) chk("lk_cnt5", dut.lock_cnt, 1);
            if (k == 19) chk("lk_cnt19", dut.lock_cnt, 15);
            if (k == 20) chk("lk_st20", dut.state, IDLE);
            tick();
        end
        idle_all();

        // lock drop: DMA takes lock, then d_req drops at cycle 3
        tick();
        bus.d_req = 1; bus.d_lock = 1; bus.d_we = 1;
        #3;
        chk("ld_enter", bus.d_gnt, 1);
        tick();
        bus.c_req = 1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.d_req = 0;
            #3;
            chk($sformatf("ld_c%0d", k), bus.c_gnt, (k == 3) ? 1 : 0);
            chk($sformatf("ld_d%0d", k), bus.d_gnt, (k == 3) ? 0 : 1);
            tick();
        end
        idle_all();
        #3;
        chk("ld_state", dut.state, IDLE);

        // reset mid-read
        tick();
        bus.c_req = 1; bus.c_addr = 16'h0005;
        #3;
        chk("rmr_gnt", bus.c_gnt, 1);
        tick();
        reset = 1; bus.c_req = 0;
        #3;
        chk("rmr_rv1", bus.c_rvalid, 0);
        chk("rmr_rd1", bus.c_rdata, 0);
        tick();
        reset = 0;
        #3;
        chk("rmr_rv2", bus.c_rvalid, 0);

        // reset mid-lock
        tick();
        bus.d_req = 1; bus.d_lock = 1; bus.d_we = 1;
        tick();
        bus.c_req = 1;
        #3;
        chk("rml_d", bus.d_gnt, 1);
        chk("rml_st", dut.state, DMA_LOCK);
        chk("rml_cnt", dut.lock_cnt, 1);
        tick();
        reset = 1;
        #3;
        chk("rml_rst_d", bus.d_gnt, 0);
        chk("rml_rst_en", bus.mem_en, 0);
        tick();
        #3;
        chk("rml_st0", dut.state, IDLE);
        chk("rml_lcnt0", dut.lock_cnt, 0);
        chk("rml_wcnt0", dut.wait_cnt, 0);
        tick();
        reset = 0;
        #3;
        chk("rml_cwin", bus.c_gnt, 1);
        chk("rml_dlose", bus.d_gnt, 0);
        tick();
        idle_all();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
